// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    StAssert,
    StWait,
    StRun
  } seq_state_e;

  localparam int unsigned RETRY_W = 4;

  // Width that holds any of the three cycle counts, with a spare bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                            input int unsigned lock_cycles,
                                            input int unsigned timeout_cycles);
    int unsigned m;
    m = rst_cycles;
    if (lock_cycles > m) m = lock_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module bit_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Releases a chain of dependent PLLs one at a time, then the downstream domains,
// with lock-loss restart, lock-wait timeout/retry and sticky diagnostics.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned N_PLL          = 2,
  parameter int unsigned N_DOM          = 2,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [N_PLL-1:0]           sw_pll_reset,
  input  logic [N_DOM-1:0]           sw_dom_reset,
  input  logic [N_PLL-1:0]           pll_locked,
  input  logic                       lock_lost_clr,
  output logic [N_PLL-1:0]           pll_reset,
  output logic [N_DOM-1:0]           dom_reset,
  output logic                       seq_done,
  output logic [N_PLL-1:0]           lock_lost,
  output logic [N_PLL-1:0]           timeout_flag,
  output logic [RETRY_W-1:0]         retry_cnt,
  output logic [$clog2(N_PLL):0]     cur_idx
);

  localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned IDX_W = $clog2(N_PLL) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PLL - 1);
  localparam logic [IDX_W-1:0] RUN_IDX   = IDX_W'(N_PLL);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [N_PLL-1:0] lk;

  for (genvar g = 0; g < N_PLL; g++) begin : gen_sync
    bit_sync2 u_sync (
      .clk_i  (clk_clk),
      .rst_ni (reset_reset_n),
      .d_i    (pll_locked[g]),
      .q_o    (lk[g])
    );
  end

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [N_PLL-1:0]   pll_reset_q, pll_reset_d;
  logic [N_DOM-1:0]   dom_reset_q, dom_reset_d;
  logic               seq_done_q, seq_done_d;
  logic [N_PLL-1:0]   lock_lost_q, lock_lost_d;
  logic [N_PLL-1:0]   timeout_q, timeout_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic               fault;
  logic               fault_lock;
  logic [IDX_W-1:0]   fault_idx;
  logic               cur_lk;
  logic [N_PLL-1:0]   lost_set;
  logic [N_PLL-1:0]   tmo_set;
  logic               retry_inc;

  // Fault scan: indices below idx are confirmed; RUN uses idx = N_PLL so every PLL qualifies.
  always_comb begin
    fault      = 1'b0;
    fault_lock = 1'b0;
    fault_idx  = '0;
    cur_lk     = 1'b0;
    for (int k = N_PLL - 1; k >= 0; k--) begin
      if (IDX_W'(k) == idx_q) cur_lk = lk[k];
      if ((IDX_W'(k) < idx_q && !lk[k]) || (IDX_W'(k) <= idx_q && sw_pll_reset[k])) begin
        fault      = 1'b1;
        fault_idx  = IDX_W'(k);
        fault_lock = (IDX_W'(k) < idx_q) && !lk[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    lost_set  = '0;
    tmo_set   = '0;
    retry_inc = 1'b0;

    if (fault) begin
      state_d  = StAssert;
      idx_d    = fault_idx;
      cnt_d    = '0;
      wait_d   = '0;
      lost_set = fault_lock ? (N_PLL'(1) << fault_idx) : '0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == RST_LAST) begin
            state_d = StWait;
            cnt_d   = '0;
            wait_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StWait: begin
          if (cur_lk && cnt_q == LOCK_LAST) begin
            cnt_d  = '0;
            wait_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = StRun;
              idx_d   = RUN_IDX;
            end else begin
              state_d = StAssert;
              idx_d   = idx_q + IDX_W'(1);
            end
          end else if (wait_q == TMO_LAST) begin
            state_d   = StAssert;
            cnt_d     = '0;
            wait_d    = '0;
            tmo_set   = N_PLL'(1) << idx_q;
            retry_inc = 1'b1;
          end else begin
            cnt_d  = cur_lk ? cnt_q + CNT_W'(1) : '0;
            wait_d = wait_q + CNT_W'(1);
          end
        end
        StRun: ;
        default: begin
          state_d = StAssert;
          idx_d   = '0;
          cnt_d   = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change together with it.
  always_comb begin
    pll_reset_d = '0;
    for (int j = 0; j < N_PLL; j++) begin
      case (state_d)
        StAssert: pll_reset_d[j] = IDX_W'(j) >= idx_d;
        StWait:   pll_reset_d[j] = IDX_W'(j) > idx_d;
        default:  pll_reset_d[j] = 1'b0;
      endcase
    end
    seq_done_d  = (state_d == StRun);
    dom_reset_d = ~{N_DOM{seq_done_q}} | sw_dom_reset;
    // A set in the same cycle as a clear wins.
    lock_lost_d = (lock_lost_q & ~{N_PLL{lock_lost_clr}}) | lost_set;
    timeout_d   = (timeout_q & ~{N_PLL{lock_lost_clr}}) | tmo_set;
    retry_d     = retry_q;
    if (retry_inc && retry_q != {RETRY_W{1'b1}}) retry_d = retry_q + RETRY_W'(1);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= StAssert;
      idx_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      pll_reset_q <= '1;
      dom_reset_q <= '1;
      seq_done_q  <= 1'b0;
      lock_lost_q <= '0;
      timeout_q   <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      pll_reset_q <= pll_reset_d;
      dom_reset_q <= dom_reset_d;
      seq_done_q  <= seq_done_d;
      lock_lost_q <= lock_lost_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign dom_reset    = dom_reset_q;
  assign seq_done     = seq_done_q;
  assign lock_lost    = lock_lost_q;
  assign timeout_flag = timeout_q;
  assign retry_cnt    = retry_q;
  assign cur_idx      = idx_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: vector table for the main sequence, hand-written runs for glitch/timeout/reset.
module tb_pll_reset_sequencer;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [1:0] sw_pll_reset;
  logic [1:0] sw_dom_reset;
  logic [1:0] pll_locked;
  logic       lock_lost_clr;
  logic [1:0] pll_reset;
  logic [1:0] dom_reset;
  logic       seq_done;
  logic [1:0] lock_lost;
  logic [1:0] timeout_flag;
  logic [3:0] retry_cnt;
  logic [1:0] cur_idx;

  always #5 clk_clk = ~clk_clk;

  pll_reset_sequencer #(
    .N_PLL          (2),
    .N_DOM          (2),
    .RST_CYCLES     (4),
    .LOCK_CYCLES    (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .sw_pll_reset  (sw_pll_reset),
    .sw_dom_reset  (sw_dom_reset),
    .pll_locked    (pll_locked),
    .lock_lost_clr (lock_lost_clr),
    .pll_reset     (pll_reset),
    .dom_reset     (dom_reset),
    .seq_done      (seq_done),
    .lock_lost     (lock_lost),
    .timeout_flag  (timeout_flag),
    .retry_cnt     (retry_cnt),
    .cur_idx       (cur_idx)
  );

  typedef struct packed {
    logic [1:0] pll;
    logic [1:0] dom;
    logic       done;
    logic [1:0] lost;
    logic [1:0] tmo;
    logic [3:0] retry;
    logic [1:0] idx;
  } obs_t;

  typedef struct {
    int         n;
    logic       rstn;
    logic [1:0] swp;
    logic [1:0] swd;
    logic [1:0] lk;
    logic       clr;
    obs_t       exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t mk(input logic [1:0] pll, input logic [1:0] dom, input logic done,
                              input logic [1:0] lost, input logic [1:0] tmo,
                              input logic [3:0] retry, input logic [1:0] idx);
    obs_t o;
    o.pll = pll; o.dom = dom; o.done = done; o.lost = lost;
    o.tmo = tmo; o.retry = retry; o.idx = idx;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pll=%b dom=%b done=%b lost=%b tmo=%b retry=%0d idx=%0d",
                     o.pll, o.dom, o.done, o.lost, o.tmo, o.retry, o.idx);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = mk(pll_reset, dom_reset, seq_done, lock_lost, timeout_flag, retry_cnt, cur_idx);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic add(input int n, input logic rstn, input logic [1:0] swp, input logic [1:0] swd,
                     input logic [1:0] lk, input logic clr, input obs_t exp, input string name);
    vec_t v;
    v.n = n; v.rstn = rstn; v.swp = swp; v.swd = swd; v.lk = lk; v.clr = clr;
    v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    sw_pll_reset  = 2'b00;
    sw_dom_reset  = 2'b00;
    pll_locked    = 2'b00;
    lock_lost_clr = 1'b0;

    // n, rstn, sw_pll, sw_dom, locked, clr, {pll dom done lost tmo retry idx}
    add(2,  0, 2'b00, 2'b00, 2'b00, 0, mk(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0), "reset");
    add(3,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0), "assert0_hold");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 0), "pll0_release");
    add(7,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 0), "wait0_confirm");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 1), "assert1_enter");
    add(3,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 1), "assert1_hold");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b11, 0, 2'b00, 2'b00, 0, 1), "pll1_release");
    add(7,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b11, 0, 2'b00, 2'b00, 0, 1), "wait1_confirm");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b11, 1, 2'b00, 2'b00, 0, 2), "run_enter");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 2), "dom_release");
    add(1,  1, 2'b00, 2'b10, 2'b11, 0, mk(2'b00, 2'b10, 1, 2'b00, 2'b00, 0, 2), "sw_dom1_on");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 2), "sw_dom1_off");
    add(2,  1, 2'b00, 2'b00, 2'b01, 0, mk(2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 2), "lk1_drop_sync");
    add(1,  1, 2'b00, 2'b00, 2'b01, 0, mk(2'b10, 2'b00, 0, 2'b10, 2'b00, 0, 1), "lk1_drop_restart");
    add(1,  1, 2'b00, 2'b00, 2'b01, 0, mk(2'b10, 2'b11, 0, 2'b10, 2'b00, 0, 1), "lk1_drop_dom");
    add(10, 1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b11, 0, 2'b10, 2'b00, 0, 1), "lk1_relock_wait");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b11, 1, 2'b10, 2'b00, 0, 2), "lk1_relock_run");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 2), "lk1_relock_dom");
    add(1,  1, 2'b00, 2'b00, 2'b11, 1, mk(2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 2), "clr_lost");
    add(2,  1, 2'b00, 2'b00, 2'b10, 0, mk(2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 2), "lk0_drop_sync");
    add(1,  1, 2'b00, 2'b00, 2'b10, 0, mk(2'b11, 2'b00, 0, 2'b01, 2'b00, 0, 0), "lk0_drop_restart");
    add(1,  1, 2'b00, 2'b00, 2'b10, 0, mk(2'b11, 2'b11, 0, 2'b01, 2'b00, 0, 0), "lk0_drop_dom");
    add(11, 1, 2'b00, 2'b00, 2'b11, 0, mk(2'b10, 2'b11, 0, 2'b01, 2'b00, 0, 1), "rerun_stage1");
    add(4,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b11, 0, 2'b01, 2'b00, 0, 1), "rerun_pll1_release");
    add(8,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b11, 1, 2'b01, 2'b00, 0, 2), "rerun_run");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b00, 2'b00, 1, 2'b01, 2'b00, 0, 2), "rerun_dom");
    add(1,  1, 2'b01, 2'b00, 2'b11, 0, mk(2'b11, 2'b00, 0, 2'b01, 2'b00, 0, 0), "sw_pll0_restart");
    add(6,  1, 2'b01, 2'b00, 2'b11, 0, mk(2'b11, 2'b11, 0, 2'b01, 2'b00, 0, 0), "sw_pll0_held");
    add(3,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b11, 2'b11, 0, 2'b01, 2'b00, 0, 0), "sw_pll0_count");
    add(1,  1, 2'b00, 2'b00, 2'b11, 0, mk(2'b10, 2'b11, 0, 2'b01, 2'b00, 0, 0), "sw_pll0_release");

    foreach (vecs[i]) begin
      reset_reset_n = vecs[i].rstn;
      sw_pll_reset  = vecs[i].swp;
      sw_dom_reset  = vecs[i].swd;
      pll_locked    = vecs[i].lk;
      lock_lost_clr = vecs[i].clr;
      tick(vecs[i].n);
      check(vecs[i].name, vecs[i].exp);
    end

    // Lock glitch: lk[0] high 5, low 1, then high; stage-1 release moves 6 cycles later.
    reset_reset_n = 1'b0;
    sw_pll_reset  = 2'b00;
    sw_dom_reset  = 2'b00;
    pll_locked    = 2'b00;
    lock_lost_clr = 1'b0;
    tick(2);
    check("glitch_reset", mk(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0));
    reset_reset_n = 1'b1;
    pll_locked    = 2'b11;
    tick(7);
    pll_locked = 2'b10;
    tick(1);
    pll_locked = 2'b11;
    tick(4);
    check("glitch_no_early_adv", mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 0));
    tick(5);
    check("glitch_last_wait0", mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 0));
    tick(1);
    check("glitch_assert1", mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 1));
    tick(3);
    check("glitch_assert1_hold", mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 1));
    tick(1);
    check("glitch_pll1_release", mk(2'b00, 2'b11, 0, 2'b00, 2'b00, 0, 1));

    // PLL 1 never locks: timeout every 68 cycles, retry_cnt saturates at 15.
    pll_locked = 2'b01;
    tick(63);
    check("tmo_before", mk(2'b00, 2'b11, 0, 2'b00, 2'b00, 0, 1));
    tick(1);
    check("tmo_first", mk(2'b10, 2'b11, 0, 2'b00, 2'b10, 1, 1));
    for (int r = 2; r <= 16; r++) begin
      int unsigned e;
      e = (r > 15) ? 15 : r;
      tick(68);
      check($sformatf("tmo_retry_%0d", r), mk(2'b10, 2'b11, 0, 2'b00, 2'b10, 4'(e), 1));
    end
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
    check("tmo_clr", mk(2'b10, 2'b11, 0, 2'b00, 2'b00, 15, 1));
    tick(66);
    check("tmo_wait_again", mk(2'b00, 2'b11, 0, 2'b00, 2'b00, 15, 1));
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
    check("tmo_set_beats_clr", mk(2'b10, 2'b11, 0, 2'b00, 2'b10, 15, 1));

    // Synchronous reset in the middle of WAIT(1).
    tick(4);
    check("mid_wait", mk(2'b00, 2'b11, 0, 2'b00, 2'b10, 15, 1));
    reset_reset_n = 1'b0;
    tick(1);
    check("mid_wait_reset", mk(2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0));
    reset_reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
